// File: rtl/branch_target_predictor_pkg.sv
// Shared constants and types for the branch target predictor.
// Opcode encodings match the RV32I control-flow instructions.
// The update-kind enum names the one table write made per resolve.
package branch_target_predictor_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Table write selected for the resolving instruction
  typedef enum logic [2:0] {
    UPD_NONE,       // nothing written
    UPD_TRAIN,      // branch hit: step counter, refresh target when taken
    UPD_ALLOC_BR,   // branch miss, taken: allocate weakly taken
    UPD_ALLOC_JAL,  // JAL: allocate or overwrite strongly taken
    UPD_INVAL       // JALR hit: drop the entry
  } upd_e;

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch-lookup / execute-resolve bus between the pipeline and the predictor.
// Lookup outputs and the mispredict flag are combinational; no back-pressure.
// The pipeline drives through the master modport, the predictor uses slave.
interface branch_target_predictor_if #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 32
);
  import branch_target_predictor_pkg::*;

  logic             f_valid;
  logic [PC_W-1:0]  f_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;

  logic             e_valid;
  logic             e_is_branch;
  logic             e_is_jal;
  logic             e_is_jalr;
  logic [PC_W-1:0]  e_pc;
  logic             e_taken;
  logic [PC_W-1:0]  e_target;
  logic             e_pred_taken;
  logic [PC_W-1:0]  e_pred_target;
  logic             e_mispredict;
  logic [PC_W-1:0]  e_redirect_pc;

  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output f_valid, f_pc,
    output e_valid, e_is_branch, e_is_jal, e_is_jalr, e_pc, e_taken, e_target,
    output e_pred_taken, e_pred_target,
    input  pred_taken, pred_target, e_mispredict, e_redirect_pc,
    input  branch_count, mispred_count
  );

  modport slave (
    input  f_valid, f_pc,
    input  e_valid, e_is_branch, e_is_jal, e_is_jalr, e_pc, e_taken, e_target,
    input  e_pred_taken, e_pred_target,
    output pred_taken, pred_target, e_mispredict, e_redirect_pc,
    output branch_count, mispred_count
  );

endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down counter next-value function (no state).
// Latency: combinational. Backpressure: none.
// Holds at 0 on decrement and at all-ones on increment.
module sat_counter
  import branch_target_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  // Step once in the requested direction unless already at the rail
  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != {W{1'b1}})) begin
      nxt = cur + W'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counters plus perf counters.
// Latency: lookup and mispredict are combinational; training lands on the next edge.
// Backpressure: none, accepts a lookup and a resolve every cycle.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic clock,
  input  logic reset,
  branch_target_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_T   = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_STRONG_T = {CTR_W{1'b1}};

  // Flop arrays: the fetch lookup reads asynchronously
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             resolve;
  logic [PC_W-1:0]  act_next;
  logic             mispredict;
  logic [CTR_W-1:0] ctr_nxt;
  upd_e             upd;

  assign f_idx = bus.f_pc[IDX_W+1:2];
  assign f_tag = bus.f_pc[PC_W-1:IDX_W+2];
  assign e_idx = bus.e_pc[IDX_W+1:2];
  assign e_tag = bus.e_pc[PC_W-1:IDX_W+2];

  // Fetch lookup: old table contents, so a same-cycle update is not seen yet
  always_comb begin
    f_hit           = bus.f_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    bus.pred_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
    bus.pred_target = bus.pred_taken ? target_q[f_idx] : bus.f_pc + PC_W'(4);
  end

  // Resolve: compare the carried prediction against the real next PC
  always_comb begin
    resolve  = reset && bus.e_valid && (bus.e_is_branch || bus.e_is_jal || bus.e_is_jalr);
    e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    act_next = bus.e_taken ? bus.e_target : bus.e_pc + PC_W'(4);
    mispredict = 1'b0;
    if (resolve) begin
      mispredict = (bus.e_taken != bus.e_pred_taken) || (bus.e_pred_target != act_next);
    end
    bus.e_mispredict  = mispredict;
    bus.e_redirect_pc = resolve ? act_next : bus.e_pc + PC_W'(4);
  end

  // Pick the single table write for this resolve; JAL wins over JALR over branch
  always_comb begin
    upd = UPD_NONE;
    if (resolve) begin
      if (bus.e_is_jal) begin
        upd = UPD_ALLOC_JAL;
      end else if (bus.e_is_jalr) begin
        upd = e_hit ? UPD_INVAL : UPD_NONE;
      end else if (e_hit) begin
        upd = UPD_TRAIN;
      end else if (bus.e_taken) begin
        upd = UPD_ALLOC_BR;
      end
    end
  end

  sat_counter #(.W(CTR_W)) u_sat_counter (
    .cur (ctr_q[e_idx]),
    .inc (bus.e_taken),
    .dec (!bus.e_taken),
    .nxt (ctr_nxt)
  );

  // Train the tables and count; reset drops any update in the same cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispredict) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
      case (upd)
        UPD_TRAIN: begin
          ctr_q[e_idx] <= ctr_nxt;
          if (bus.e_taken) target_q[e_idx] <= bus.e_target;
        end
        UPD_ALLOC_BR: begin
          valid_q[e_idx]  <= 1'b1;
          tag_q[e_idx]    <= e_tag;
          target_q[e_idx] <= bus.e_target;
          ctr_q[e_idx]    <= CTR_WEAK_T;
        end
        UPD_ALLOC_JAL: begin
          valid_q[e_idx]  <= 1'b1;
          tag_q[e_idx]    <= e_tag;
          target_q[e_idx] <= bus.e_target;
          ctr_q[e_idx]    <= CTR_STRONG_T;
        end
        UPD_INVAL: valid_q[e_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.branch_count  = branch_cnt_q;
  assign bus.mispred_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed table of lookup/resolve vectors with hand-computed results,
// followed by short sequences for f_valid gating and mid-run reset.
// ENTRIES=16: 0x040, 0x080, 0x0C0 and 0x100 all share index 0.
module tb_branch_target_predictor;

  localparam int PC_W  = 12;
  localparam int CNT_W = 32;
  localparam int NV    = 29;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_BR   = 2'd1;
  localparam logic [1:0] K_JAL  = 2'd2;
  localparam logic [1:0] K_JALR = 2'd3;

  typedef struct {
    logic            fv;
    logic [PC_W-1:0] fpc;
    logic            ev;
    logic [1:0]      kind;
    logic            tk;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] etgt;
    logic            ept;
    logic [PC_W-1:0] eptgt;
    logic            xpt;
    logic [PC_W-1:0] xptgt;
    logic            xmp;
    logic [PC_W-1:0] xrpc;
    int              xbc;
    int              xmc;
  } vec_t;

  logic clock;
  logic reset;
  vec_t vecs [NV];
  int   n_vec;
  int   n_fail;

  branch_target_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_target_predictor #(.PC_W(PC_W), .ENTRIES(16), .CTR_W(2), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic fv, input logic [PC_W-1:0] fpc, input logic ev,
                              input logic [1:0] kind, input logic tk, input logic [PC_W-1:0] epc,
                              input logic [PC_W-1:0] etgt, input logic ept, input logic [PC_W-1:0] eptgt,
                              input logic xpt, input logic [PC_W-1:0] xptgt, input logic xmp,
                              input logic [PC_W-1:0] xrpc, input int xbc, input int xmc);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.ev = ev; v.kind = kind; v.tk = tk; v.epc = epc; v.etgt = etgt;
    v.ept = ept; v.eptgt = eptgt; v.xpt = xpt; v.xptgt = xptgt; v.xmp = xmp; v.xrpc = xrpc;
    v.xbc = xbc; v.xmc = xmc;
    return v;
  endfunction

  // Lookup-only vector with an idle execute stage (e_pc = 0)
  function automatic vec_t look(input logic [PC_W-1:0] fpc, input logic xpt,
                                input logic [PC_W-1:0] xptgt, input int xbc, input int xmc);
    return mk(1'b1, fpc, 1'b0, K_NONE, 1'b0, '0, '0, 1'b0, '0, xpt, xptgt, 1'b0, 12'h004, xbc, xmc);
  endfunction

  task automatic drive(input vec_t v);
    bus.f_valid       = v.fv;
    bus.f_pc          = v.fpc;
    bus.e_valid       = v.ev;
    bus.e_is_branch   = (v.kind == K_BR);
    bus.e_is_jal      = (v.kind == K_JAL);
    bus.e_is_jalr     = (v.kind == K_JALR);
    bus.e_taken       = v.tk;
    bus.e_pc          = v.epc;
    bus.e_target      = v.etgt;
    bus.e_pred_taken  = v.ept;
    bus.e_pred_target = v.eptgt;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the negedge drive, well clear of posedge
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    #1;
    n_vec++;
    check("pred_taken",    idx, 32'(bus.pred_taken),    32'(v.xpt));
    check("pred_target",   idx, 32'(bus.pred_target),   32'(v.xptgt));
    check("e_mispredict",  idx, 32'(bus.e_mispredict),  32'(v.xmp));
    check("e_redirect_pc", idx, 32'(bus.e_redirect_pc), 32'(v.xrpc));
    check("branch_count",  idx, bus.branch_count,       32'(v.xbc));
    check("mispred_count", idx, bus.mispred_count,      32'(v.xmc));
    @(negedge clock);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    vecs[0]  = look(12'h040, 0, 12'h044, 0, 0);
    vecs[1]  = mk(1, 12'h040, 1, K_BR, 1, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 1, 12'h010, 0, 0);
    vecs[2]  = mk(1, 12'h040, 1, K_BR, 0, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 1, 12'h044, 1, 1);
    vecs[3]  = mk(1, 12'h040, 1, K_BR, 0, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 0, 12'h044, 2, 2);
    vecs[4]  = mk(1, 12'h040, 1, K_BR, 0, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 0, 12'h044, 3, 2);
    vecs[5]  = mk(1, 12'h040, 1, K_BR, 1, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 1, 12'h010, 4, 2);
    vecs[6]  = mk(1, 12'h040, 1, K_BR, 1, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 1, 12'h010, 5, 3);
    vecs[7]  = mk(1, 12'h040, 1, K_BR, 1, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 0, 12'h010, 6, 4);
    vecs[8]  = mk(1, 12'h040, 1, K_BR, 1, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 0, 12'h010, 7, 4);
    vecs[9]  = mk(1, 12'h040, 1, K_BR, 1, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 0, 12'h010, 8, 4);
    vecs[10] = mk(1, 12'h040, 1, K_BR, 0, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 1, 12'h044, 9, 4);
    vecs[11] = look(12'h040, 1, 12'h010, 10, 5);
    vecs[12] = look(12'h080, 0, 12'h084, 10, 5);
    vecs[13] = mk(1, 12'h080, 1, K_BR, 1, 12'h080, 12'h020, 0, 12'h084, 0, 12'h084, 1, 12'h020, 10, 5);
    vecs[14] = look(12'h040, 0, 12'h044, 11, 6);
    vecs[15] = look(12'h080, 1, 12'h020, 11, 6);
    vecs[16] = mk(1, 12'h080, 1, K_BR, 0, 12'h0C0, 12'h000, 0, 12'h0C4, 1, 12'h020, 0, 12'h0C4, 11, 6);
    vecs[17] = look(12'h080, 1, 12'h020, 12, 6);
    vecs[18] = mk(1, 12'h100, 1, K_JAL, 1, 12'h100, 12'h200, 0, 12'h104, 0, 12'h104, 1, 12'h200, 12, 6);
    vecs[19] = look(12'h100, 1, 12'h200, 13, 7);
    vecs[20] = mk(1, 12'h100, 1, K_JALR, 1, 12'h100, 12'h300, 1, 12'h200, 1, 12'h200, 1, 12'h300, 13, 7);
    vecs[21] = look(12'h100, 0, 12'h104, 14, 8);
    vecs[22] = mk(1, 12'h040, 1, K_JAL, 1, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 1, 12'h010, 14, 8);
    vecs[23] = mk(1, 12'h040, 1, K_BR, 0, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 1, 12'h044, 15, 9);
    vecs[24] = mk(1, 12'h040, 1, K_BR, 0, 12'h040, 12'h010, 1, 12'h010, 1, 12'h010, 1, 12'h044, 16, 10);
    vecs[25] = look(12'h040, 0, 12'h044, 17, 11);
    vecs[26] = look(12'hFFC, 0, 12'h000, 17, 11);
    vecs[27] = mk(1, 12'h040, 0, K_BR, 1, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 0, 12'h044, 17, 11);
    vecs[28] = look(12'h040, 0, 12'h044, 17, 11);

    reset = 1'b0;
    drive(look(12'h040, 0, 12'h044, 0, 0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // Allocate 0x100 by JAL, then confirm f_valid gates a hit
    apply(mk(1, 12'h100, 1, K_JAL, 1, 12'h100, 12'h200, 0, 12'h104, 0, 12'h104, 1, 12'h200, 17, 11), 100);
    apply(look(12'h100, 1, 12'h200, 18, 12), 101);
    apply(mk(0, 12'h100, 0, K_NONE, 0, 12'h000, 12'h000, 0, 12'h000, 0, 12'h104, 0, 12'h004, 18, 12), 102);

    // Reset pulse with a JAL in flight: the write and the counts must be lost
    drive(mk(1, 12'h040, 1, K_JAL, 1, 12'h040, 12'h010, 0, 12'h044, 0, 12'h044, 0, 12'h010, 0, 0));
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    apply(look(12'h100, 0, 12'h104, 0, 0), 103);
    apply(look(12'h040, 0, 12'h044, 0, 0), 104);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
